// File: rtl/cmos_frame_capture.sv
// Capture stage between the OV5640 byte bus and the frame-buffer write port.
// Pairs sensor bytes into RGB565 pixels, skips start-up frames, crops a window and checks geometry.
module cmos_frame_capture #(
    parameter int SKIP_FRAMES = 3,
    parameter int H_ACTIVE    = 1024,
    parameter int V_ACTIVE    = 768,
    parameter int CROP_X0     = 0,
    parameter int CROP_Y0     = 0,
    parameter int CROP_W      = 1024,
    parameter int CROP_H      = 768,
    parameter int CNT_W       = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_db,
    output logic        pix_de,
    output logic [15:0] pix_data,
    output logic        pix_vs_n,
    output logic        capturing,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err,
    output logic [7:0]  frame_cnt
);

    localparam int SKIP_W = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  H_EXP     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]  V_EXP     = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W:0]    X_LO      = (CNT_W+1)'(CROP_X0);
    localparam logic [CNT_W:0]    X_HI      = (CNT_W+1)'(CROP_X0 + CROP_W);
    localparam logic [CNT_W:0]    Y_LO      = (CNT_W+1)'(CROP_Y0);
    localparam logic [CNT_W:0]    Y_HI      = (CNT_W+1)'(CROP_Y0 + CROP_H);

    typedef enum logic [1:0] {IDLE, SKIP, CAPTURE} state_t;

    state_t            state, next_state;
    logic [SKIP_W-1:0] skip_cnt;
    logic              vs_d, vs_d_prev, hr_d, line_on_prev;
    logic [7:0]        db_d, hi_byte;
    logic              phase;
    logic [CNT_W-1:0]  x, y;
    logic              px_valid;
    logic [15:0]       px_word;

    // href during a vsync pulse is treated as no line at all
    logic line_on, vs_rise, hr_fall, px_done, in_crop, frame_close;
    assign line_on     = hr_d & ~vs_d;
    assign vs_rise     = vs_d & ~vs_d_prev;
    assign hr_fall     = ~line_on & line_on_prev;
    assign px_done     = line_on & phase;
    assign in_crop     = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
                         ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
    assign frame_close = (state == CAPTURE) && vs_rise && (y != '0);

    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d         <= 1'b0;
            vs_d_prev    <= 1'b0;
            hr_d         <= 1'b0;
            line_on_prev <= 1'b0;
            db_d         <= '0;
        end else begin
            vs_d         <= cmos_vsync;
            vs_d_prev    <= vs_d;
            hr_d         <= cmos_href;
            line_on_prev <= line_on;
            db_d         <= cmos_db;
        end
    end

    // NOTE: next_state gets a default first so the combinational block never infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (vs_rise) next_state = (SKIP_FRAMES == 0) ? CAPTURE : SKIP;
            SKIP:    if (vs_rise && skip_cnt == SKIP_LAST) next_state = CAPTURE;
            CAPTURE: next_state = CAPTURE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            skip_cnt  <= '0;
            capturing <= 1'b0;
            pix_vs_n  <= 1'b1;
        end else begin
            state     <= next_state;
            capturing <= (next_state == CAPTURE);
            pix_vs_n  <= ~(vs_d & (next_state == CAPTURE));
            if (state == SKIP && vs_rise && next_state != CAPTURE)
                skip_cnt <= skip_cnt + 1'b1;
        end
    end

    // Byte pairing and position counters; both counters saturate instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= 1'b0;
            hi_byte <= '0;
            x       <= '0;
            y       <= '0;
        end else begin
            phase <= line_on ? ~phase : 1'b0;
            if (line_on && !phase)
                hi_byte <= db_d;
            if (vs_rise || hr_fall)
                x <= '0;
            else if (px_done && x != CNT_MAX)
                x <= x + 1'b1;
            if (vs_rise)
                y <= '0;
            else if (hr_fall && x != '0 && y != CNT_MAX)
                y <= y + 1'b1;
        end
    end

    // Two-stage pixel path gives the fixed two-edge latency from the second byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_valid <= 1'b0;
            px_word  <= '0;
            pix_de   <= 1'b0;
            pix_data <= '0;
        end else begin
            px_valid <= px_done && (state == CAPTURE) && in_crop;
            if (px_done)
                px_word <= {hi_byte, db_d};
            pix_de <= px_valid;
            if (px_valid)
                pix_data <= px_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_err   <= 1'b0;
            frame_err  <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            line_err   <= (state == CAPTURE) && hr_fall && (phase || x != H_EXP);
            frame_done <= frame_close;
            frame_err  <= frame_close && (y != V_EXP);
            if (frame_close)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_cmos_frame_capture.sv
// Drives random sensor frames into three differently configured captures and compares
// each against a per-frame reference computed from the byte/line description.
module tb_cmos_frame_capture;

    localparam int H_ACT = 8;
    localparam int V_ACT = 4;
    localparam int SKIP [3] = '{2, 2, 0};
    localparam int X0   [3] = '{0, 2, 0};
    localparam int W    [3] = '{8, 4, 8};
    localparam int Y0   [3] = '{0, 1, 0};
    localparam int H    [3] = '{4, 2, 4};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmos_vsync = 1'b0;
    logic        cmos_href = 1'b0;
    logic [7:0]  cmos_db = '0;

    logic        de [3];
    logic [15:0] pd [3];
    logic        vsn [3];
    logic        cap [3];
    logic        fd [3];
    logic        le [3];
    logic        fe [3];
    logic [7:0]  fc [3];

    always #5 clk = ~clk;

    cmos_frame_capture #(.SKIP_FRAMES(2), .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT),
        .CROP_X0(0), .CROP_Y0(0), .CROP_W(8), .CROP_H(4), .CNT_W(12)) dut_a (
        .clk(clk), .rst_n(rst_n), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_db(cmos_db),
        .pix_de(de[0]), .pix_data(pd[0]), .pix_vs_n(vsn[0]), .capturing(cap[0]),
        .frame_done(fd[0]), .line_err(le[0]), .frame_err(fe[0]), .frame_cnt(fc[0]));

    cmos_frame_capture #(.SKIP_FRAMES(2), .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT),
        .CROP_X0(2), .CROP_Y0(1), .CROP_W(4), .CROP_H(2), .CNT_W(12)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_db(cmos_db),
        .pix_de(de[1]), .pix_data(pd[1]), .pix_vs_n(vsn[1]), .capturing(cap[1]),
        .frame_done(fd[1]), .line_err(le[1]), .frame_err(fe[1]), .frame_cnt(fc[1]));

    cmos_frame_capture #(.SKIP_FRAMES(0), .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT),
        .CROP_X0(0), .CROP_Y0(0), .CROP_W(8), .CROP_H(4), .CNT_W(12)) dut_c (
        .clk(clk), .rst_n(rst_n), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_db(cmos_db),
        .pix_de(de[2]), .pix_data(pd[2]), .pix_vs_n(vsn[2]), .capturing(cap[2]),
        .frame_done(fd[2]), .line_err(le[2]), .frame_err(fe[2]), .frame_cnt(fc[2]));

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Reference state: vsyncs since reset, pixel-bearing lines of the last frame, frames closed.
    int vs_cnt = 0;
    int prev_y = 0;
    int frames [3] = '{0, 0, 0};

    logic [15:0] got [3][$];
    int mon_done [3];
    int mon_ferr [3];
    int mon_lerr [3];
    bit mon_vslow [3];

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                if (de[d]) got[d].push_back(pd[d]);
                if (fd[d]) mon_done[d]++;
                if (fe[d]) mon_ferr[d]++;
                if (le[d]) mon_lerr[d]++;
                if (!vsn[d]) mon_vslow[d] = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_frame(input int lens[$], input bit directed);
        logic [7:0]  b [$];
        logic [15:0] expq [3][$];
        int          exp_done [3];
        int          exp_ferr [3];
        int          exp_lerr [3];
        bit          cap_before;
        bit          cap_after [3];
        int          yl;
        int          np;
        int          n;

        for (int d = 0; d < 3; d++) begin
            got[d].delete();
            mon_done[d] = 0;
            mon_ferr[d] = 0;
            mon_lerr[d] = 0;
            mon_vslow[d] = 1'b0;
        end

        // Vsync number n closes the previous frame if capture began at an earlier vsync,
        // and the frame following vsync n is captured once n exceeds the skip count.
        vs_cnt++;
        for (int d = 0; d < 3; d++) begin
            cap_before   = (vs_cnt - 1) >= SKIP[d] + 1;
            cap_after[d] = vs_cnt >= SKIP[d] + 1;
            exp_done[d]  = (cap_before && prev_y > 0) ? 1 : 0;
            exp_ferr[d]  = (exp_done[d] == 1 && prev_y != V_ACT) ? 1 : 0;
            exp_lerr[d]  = 0;
            frames[d]   += exp_done[d];
        end

        @(negedge clk);
        cmos_vsync = 1'b1;
        repeat (2) @(negedge clk);
        cmos_vsync = 1'b0;
        repeat (3) @(negedge clk);

        yl = 0;
        foreach (lens[li]) begin
            b.delete();
            for (int i = 0; i < lens[li]; i++) b.push_back(8'($urandom));
            if (directed && li == 0) begin
                b[0] = 8'hAB;
                b[1] = 8'hCD;
            end
            np = lens[li] / 2;
            for (int j = 0; j < np; j++)
                for (int d = 0; d < 3; d++)
                    if (cap_after[d] && j >= X0[d] && j < X0[d] + W[d] && yl >= Y0[d] && yl < Y0[d] + H[d])
                        expq[d].push_back({b[2*j], b[2*j+1]});
            for (int d = 0; d < 3; d++)
                if (cap_after[d] && ((lens[li] % 2) != 0 || np != H_ACT)) exp_lerr[d]++;

            for (int i = 0; i < lens[li]; i++) begin
                @(negedge clk);
                // Second byte of pixel 0 is sampled at edge k; these are the negedges after k+1..k+3.
                if (directed && li == 0 && i >= 3 && i <= 5)
                    check($sformatf("latency_after_edge_k+%0d", i - 2), 32'(de[0]), 32'(i == 4));
                cmos_href = 1'b1;
                cmos_db   = b[i];
            end
            @(negedge clk);
            cmos_href = 1'b0;
            repeat (3) @(negedge clk);
            if (np > 0) yl++;
        end
        prev_y = yl;
        repeat (4) @(negedge clk);

        for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d_vs%0d_pix_count", d, vs_cnt), got[d].size(), expq[d].size());
            n = (got[d].size() < expq[d].size()) ? got[d].size() : expq[d].size();
            for (int k = 0; k < n; k++)
                check($sformatf("dut%0d_vs%0d_pix%0d", d, vs_cnt, k), got[d][k], expq[d][k]);
            check($sformatf("dut%0d_vs%0d_frame_done", d, vs_cnt), mon_done[d], exp_done[d]);
            check($sformatf("dut%0d_vs%0d_frame_err", d, vs_cnt), mon_ferr[d], exp_ferr[d]);
            check($sformatf("dut%0d_vs%0d_line_err", d, vs_cnt), mon_lerr[d], exp_lerr[d]);
            check($sformatf("dut%0d_vs%0d_vs_low", d, vs_cnt), 32'(mon_vslow[d]), 32'(cap_after[d]));
            check($sformatf("dut%0d_vs%0d_capturing", d, vs_cnt), 32'(cap[d]), 32'(cap_after[d]));
            check($sformatf("dut%0d_vs%0d_frame_cnt", d, vs_cnt), fc[d], frames[d] % 256);
        end
        if (directed && got[0].size() > 0)
            check("pairing_ABCD", got[0][0], 16'hABCD);
    endtask

    initial begin
        int good [$] = '{16, 16, 16, 16};
        int bad  [$] = '{16, 15, 14};

        repeat (3) @(negedge clk);
        check("rst_pix_de", 32'(de[0]), 0);
        check("rst_pix_data", pd[0], 0);
        check("rst_pix_vs_n", 32'(vsn[0]), 1);
        check("rst_capturing", 32'(cap[0]), 0);
        check("rst_frame_done", 32'(fd[0]), 0);
        check("rst_line_err", 32'(le[0]), 0);
        check("rst_frame_err", 32'(fe[0]), 0);
        check("rst_frame_cnt", fc[0], 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        drive_frame(good, 1'b0);
        drive_frame(good, 1'b0);
        drive_frame(good, 1'b1);
        drive_frame(bad, 1'b0);
        drive_frame(good, 1'b0);

        // Reset in the middle of a captured line.
        @(negedge clk);
        cmos_vsync = 1'b1;
        repeat (2) @(negedge clk);
        cmos_vsync = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            cmos_href = 1'b1;
            cmos_db   = 8'($urandom);
        end
        check("pre_rst_capturing", 32'(cap[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_pix_de", 32'(de[0]), 0);
        check("mid_rst_pix_data", pd[0], 0);
        check("mid_rst_pix_vs_n", 32'(vsn[0]), 1);
        check("mid_rst_capturing", 32'(cap[0]), 0);
        check("mid_rst_frame_cnt", fc[0], 0);
        check("mid_rst_frame_cnt_c", fc[2], 0);
        @(negedge clk);
        cmos_href = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        vs_cnt = 0;
        prev_y = 0;
        for (int d = 0; d < 3; d++) frames[d] = 0;
        repeat (2) @(negedge clk);

        while (frames[2] < 257) begin
            drive_frame(good, 1'b0);
            if (frames[2] == 256) check("frame_cnt_wrap_256", fc[2], 0);
        end
        check("frame_cnt_after_257", fc[2], 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
